auth_ctrl: RTL and testbench

Parametrised next-generation rider authorization controller for the Segway top level. Consumes bytes from the BLE UART receiver, grants or removes motor power (`pwr_up`) under Go/Stop commands, and adds two behaviours the current controller lacks: a debounced `rider_off` qualifier and an optional link-heartbeat timeout that drops into the disconnected state on BLE link loss. Sits between `UART_rx` and the balance/steering enable logic.

---
 rtl/auth_pkg.sv | 13 +
 rtl/auth_ctrl_off_dbnc.sv | 34 +++
 rtl/auth_ctrl.sv | 84 ++++++++
 tb/tb_auth_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared types and default command bytes for the rider authorization controller
package auth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PWRD = 2'b01,
        DISC = 2'b10
    } auth_state_t;

    localparam logic [7:0] GO_CMD_DEF   = 8'h47;
    localparam logic [7:0] STOP_CMD_DEF = 8'h53;

endpackage

// File: rtl/auth_ctrl_off_dbnc.sv
// rtl/auth_ctrl_off_dbnc.sv - saturating debounce counter qualifying the raw rider_off signal
module off_dbnc #(
    parameter int unsigned OFF_DBNC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rider_off,
    output logic off_q
);

    localparam int unsigned CNT_W = $clog2(OFF_DBNC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OFF_DBNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (rider_off) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign off_q = (cnt_q == CNT_MAX);

endmodule

// File: rtl/auth_ctrl.sv
// rtl/auth_ctrl.sv - Go/Stop rider authorization FSM with debounced rider_off and link heartbeat timeout
module auth_ctrl
    import auth_pkg::*;
#(
    parameter logic [7:0]  GO_CMD   = GO_CMD_DEF,
    parameter logic [7:0]  STOP_CMD = STOP_CMD_DEF,
    parameter bit          HB_EN    = 1'b1,
    parameter int unsigned HB_CYC   = 25_000_000,
    parameter int unsigned OFF_DBNC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rider_off,
    output logic       clr_rx_rdy,
    output logic       pwr_up,
    output logic [1:0] auth_state,
    output logic       link_lost
);

    localparam int unsigned HB_W = $clog2(HB_CYC + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_CYC - 1);

    auth_state_t     state_q, state_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            link_lost_q, link_lost_d;
    logic            off_q;
    logic            go, stop, timeout;

    off_dbnc #(.OFF_DBNC(OFF_DBNC)) u_off_dbnc (
        .clk       (clk),
        .rst_n     (rst_n),
        .rider_off (rider_off),
        .off_q     (off_q)
    );

    assign go         = rx_rdy && (rx_data == GO_CMD);
    assign stop       = rx_rdy && (rx_data == STOP_CMD);
    assign timeout    = HB_EN && (state_q == PWRD) && (hb_cnt_q == HB_LAST) && !rx_rdy;
    assign clr_rx_rdy = rx_rdy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go) state_d = PWRD;
            PWRD: begin
                if (stop)         state_d = off_q ? IDLE : DISC;
                else if (timeout) state_d = DISC;
            end
            // A settled rider_off takes priority over a reconnect attempt
            DISC: begin
                if (off_q)   state_d = IDLE;
                else if (go) state_d = PWRD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hb_cnt_d    = '0;
        link_lost_d = timeout;
        if (HB_EN && (state_q == PWRD) && (state_d == PWRD) && !rx_rdy) begin
            hb_cnt_d = (hb_cnt_q == HB_LAST) ? hb_cnt_q : hb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hb_cnt_q    <= '0;
            link_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_cnt_q    <= hb_cnt_d;
            link_lost_q <= link_lost_d;
        end
    end

    assign auth_state = state_q;
    assign pwr_up     = (state_q != IDLE);
    assign link_lost  = link_lost_q;

endmodule

// File: tb/tb_auth_ctrl.sv
// tb/tb_auth_ctrl.sv - table-driven bench for auth_ctrl with hand-written heartbeat and reset sequences
module tb_auth_ctrl;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rider_off;
    logic       clr_rx_rdy, pwr_up, link_lost;
    logic [1:0] auth_state;
    logic       clr0, pwr0, lost0;
    logic [1:0] state0;

    int n_tests = 0;
    int n_fail  = 0;

    auth_ctrl #(.HB_EN(1'b1), .HB_CYC(100), .OFF_DBNC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rider_off  (rider_off),
        .clr_rx_rdy (clr_rx_rdy),
        .pwr_up     (pwr_up),
        .auth_state (auth_state),
        .link_lost  (link_lost)
    );

    auth_ctrl #(.HB_EN(1'b0), .HB_CYC(100), .OFF_DBNC(4)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rider_off  (rider_off),
        .clr_rx_rdy (clr0),
        .pwr_up     (pwr0),
        .auth_state (state0),
        .link_lost  (lost0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       off;
        logic [1:0] st;
        logic       pwr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rdy, input logic [7:0] data, input logic off,
                                input logic [1:0] st, input logic pwr);
        vec_t v;
        v.rdy = rdy; v.data = data; v.off = off; v.st = st; v.pwr = pwr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [7:0] data, input logic off);
        rx_rdy = rdy; rx_data = data; rider_off = off;
    endtask

    initial begin
        int n;
        int pulses;
        drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;

        // command sequence, debounce and DISC/PWRD transitions; expected state after each edge
        add(1, 8'h41, 0, 2'b00, 0);
        add(0, 8'h00, 0, 2'b00, 0);
        add(1, 8'h47, 0, 2'b01, 1);
        add(1, 8'h53, 0, 2'b10, 1);
        add(1, 8'h53, 0, 2'b10, 1);
        add(1, 8'h47, 0, 2'b01, 1);
        add(1, 8'h53, 0, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 0, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b00, 0);
        add(1, 8'h47, 0, 2'b01, 1);
        add(1, 8'h53, 0, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(0, 8'h00, 1, 2'b10, 1);
        add(1, 8'h47, 1, 2'b00, 0);
        add(1, 8'h47, 1, 2'b01, 1);
        add(1, 8'h53, 1, 2'b00, 0);

        #12;
        check("reset pwr_up", pwr_up, 0);
        check("reset auth_state", auth_state, 0);
        check("reset link_lost", link_lost, 0);
        check("reset hb_cnt", dut.hb_cnt_q, 0);
        check("reset off_cnt", dut.u_off_dbnc.cnt_q, 0);
        rx_rdy = 1'b1;
        #1;
        check("reset clr_rx_rdy", clr_rx_rdy, 1);
        rx_rdy = 1'b0;
        #1;
        check("reset clr_rx_rdy low", clr_rx_rdy, 0);
        #5;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].data, vecs[i].off);
            #1;
            check($sformatf("vec%0d clr_rx_rdy", i), clr_rx_rdy, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d auth_state", i), auth_state, vecs[i].st);
            check($sformatf("vec%0d pwr_up", i), pwr_up, vecs[i].pwr);
            check($sformatf("vec%0d link_lost", i), link_lost, 0);
            check($sformatf("vec%0d hb_en0 state", i), state0, vecs[i].st);
        end

        // heartbeat timeout: 100 silent cycles in PWRD
        drive(1'b1, 8'h47, 1'b0);
        tick();
        check("hb go state", auth_state, 2'b01);
        drive(1'b0, 8'h00, 1'b0);
        pulses = 0;
        n = 0;
        while (n < 200 && auth_state == 2'b01) begin
            if (link_lost) pulses++;
            tick();
            n++;
        end
        check("hb timeout cycles", n, 100);
        check("hb early link_lost", pulses, 0);
        check("hb state after timeout", auth_state, 2'b10);
        check("hb pwr_up after timeout", pwr_up, 1);
        check("hb link_lost pulse", link_lost, 1);
        check("hb_en0 stays pwrd", state0, 2'b01);
        check("hb_en0 no link_lost", lost0, 0);
        tick();
        check("hb link_lost single", link_lost, 0);

        // keepalive byte every 99 cycles never times out
        drive(1'b1, 8'h47, 1'b0);
        tick();
        pulses = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 98; c++) begin
                drive(1'b0, 8'h00, 1'b0);
                tick();
                if (auth_state != 2'b01 || link_lost) pulses++;
            end
            drive(1'b1, 8'h00, 1'b0);
            tick();
            if (auth_state != 2'b01 || link_lost) pulses++;
        end
        check("keepalive no timeout", pulses, 0);
        check("keepalive state", auth_state, 2'b01);

        // asynchronous reset while in DISC
        drive(1'b1, 8'h53, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("pre-reset state", auth_state, 2'b10);
        #2;
        rst_n = 1'b0;
        rx_rdy = 1'b1;
        #1;
        check("async reset pwr_up", pwr_up, 0);
        check("async reset state", auth_state, 0);
        check("async reset hb_cnt", dut.hb_cnt_q, 0);
        check("async reset off_cnt", dut.u_off_dbnc.cnt_q, 0);
        check("async reset clr_rx_rdy", clr_rx_rdy, 1);
        drive(1'b0, 8'h00, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post-reset state", auth_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
